// File: rtl/cga_alu_seq_ralu.sv
// Registered CGA RALU: single-cycle add/sub/logic, chained ADDC and an optional
// iterative shift-add multiply, all behind a START/BUSY/DONE handshake.
module cga_alu_seq_ralu #(
   parameter int WIDTH  = 16,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             sysclk,
   input  logic             sys_rst,
   input  logic             START,
   input  logic [2:0]       OP,
   input  logic             CI,
   input  logic [WIDTH-1:0] R,
   input  logic [WIDTH-1:0] S,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] F,
   output logic [WIDTH-1:0] MH,
   output logic             CRY,
   output logic             OVF,
   output logic             SGR,
   output logic             ZF
);

   localparam int CW  = $clog2(WIDTH);
   localparam int MSB = WIDTH - 1;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_NOTR = 3'b101;
   localparam logic [2:0] OP_MUL  = 3'b110;
   localparam logic [2:0] OP_ADDC = 3'b111;

   typedef enum logic {
      ST_IDLE,
      ST_MUL
   } state_t;

   state_t               state;
   logic [CW-1:0]        count;
   logic [WIDTH-1:0]     mcand;
   logic [2*WIDTH-1:0]   prod;

   logic [WIDTH-1:0]     op_a;
   logic                 carry_in;
   logic [WIDTH:0]       sum;
   logic                 is_arith;
   logic                 maj;
   logic [WIDTH-1:0]     res_f;
   logic                 res_cry;
   logic                 res_ovf;
   logic                 res_sgr;
   logic                 res_zf;

   logic [WIDTH:0]       addend;
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   next_prod;
   logic                 start_mul;

   // Single-cycle datapath; ADDC chains through the registered CRY and ZF.
   always_comb begin
      op_a     = (OP == OP_SUB) ? ~R : R;
      carry_in = 1'b0;
      case (OP)
         OP_ADD, OP_SUB: carry_in = CI;
         OP_ADDC:        carry_in = CRY;
         default:        carry_in = 1'b0;
      endcase
      sum      = {1'b0, op_a} + {1'b0, S} + {{WIDTH{1'b0}}, carry_in};
      is_arith = (OP == OP_ADD) || (OP == OP_SUB) || (OP == OP_ADDC);

      res_f = sum[WIDTH-1:0];
      case (OP)
         OP_AND:  res_f = R & S;
         OP_OR:   res_f = R | S;
         OP_XOR:  res_f = R ^ S;
         OP_NOTR: res_f = ~R;
         OP_MUL:  res_f = '0;
         default: res_f = sum[WIDTH-1:0];
      endcase

      maj     = (op_a[MSB] & S[MSB]) | (op_a[MSB] & res_f[MSB]) | (S[MSB] & res_f[MSB]);
      res_cry = is_arith & sum[WIDTH];
      res_ovf = is_arith & (op_a[MSB] == S[MSB]) & (res_f[MSB] != op_a[MSB]);
      res_sgr = (OP != OP_MUL) & ~maj;
      res_zf  = (res_f == '0) & ((OP == OP_ADDC) ? ZF : 1'b1);
   end

   // One shift-add step: the multiplier occupies the low half of prod and is
   // consumed LSB first while the partial product grows in from the top.
   always_comb begin
      addend    = prod[0] ? {1'b0, mcand} : '0;
      mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + addend;
      next_prod = {mul_sum, prod[WIDTH-1:1]};
      start_mul = MUL_EN && (OP == OP_MUL);
   end

   // Control FSM; results and flags are only written on the DONE cycle.
   always_ff @(posedge sysclk or posedge sys_rst) begin
      if (sys_rst) begin
         state <= ST_IDLE;
         count <= '0;
         mcand <= '0;
         prod  <= '0;
         BUSY  <= 1'b0;
         DONE  <= 1'b0;
         F     <= '0;
         MH    <= '0;
         CRY   <= 1'b0;
         OVF   <= 1'b0;
         SGR   <= 1'b0;
         ZF    <= 1'b0;
      end else begin
         DONE <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (START) begin
                  if (start_mul) begin
                     mcand <= R;
                     prod  <= {{WIDTH{1'b0}}, S};
                     count <= '0;
                     BUSY  <= 1'b1;
                     state <= ST_MUL;
                  end else begin
                     F    <= res_f;
                     MH   <= '0;
                     CRY  <= res_cry;
                     OVF  <= res_ovf;
                     SGR  <= res_sgr;
                     ZF   <= res_zf;
                     DONE <= 1'b1;
                  end
               end
            end
            ST_MUL: begin
               prod  <= next_prod;
               count <= count + CW'(1);
               if (count == CW'(WIDTH - 1)) begin
                  F     <= next_prod[WIDTH-1:0];
                  MH    <= next_prod[2*WIDTH-1:WIDTH];
                  CRY   <= 1'b0;
                  OVF   <= |next_prod[2*WIDTH-1:WIDTH];
                  SGR   <= 1'b0;
                  ZF    <= ~|next_prod;
                  DONE  <= 1'b1;
                  BUSY  <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cga_alu_seq_ralu.sv
// Directed self-checking bench for cga_alu_seq_ralu; a second instance with
// MUL_EN=0 covers the reserved multiply opcode.
module tb_cga_alu_seq_ralu;

   logic        sysclk;
   logic        sys_rst;
   logic        start;
   logic        start0;
   logic [2:0]  op;
   logic        ci;
   logic [15:0] r;
   logic [15:0] s;

   logic        busy, done, cry, ovf, sgr, zf;
   logic [15:0] f, mh;
   logic        busy0, done0, cry0, ovf0, sgr0, zf0;
   logic [15:0] f0, mh0;

   int vectors;
   int miscompares;

   cga_alu_seq_ralu #(.WIDTH(16), .MUL_EN(1'b1)) dut (
      .sysclk(sysclk), .sys_rst(sys_rst), .START(start), .OP(op), .CI(ci),
      .R(r), .S(s), .BUSY(busy), .DONE(done), .F(f), .MH(mh),
      .CRY(cry), .OVF(ovf), .SGR(sgr), .ZF(zf)
   );

   cga_alu_seq_ralu #(.WIDTH(16), .MUL_EN(1'b0)) dut_nomul (
      .sysclk(sysclk), .sys_rst(sys_rst), .START(start0), .OP(op), .CI(ci),
      .R(r), .S(s), .BUSY(busy0), .DONE(done0), .F(f0), .MH(mh0),
      .CRY(cry0), .OVF(ovf0), .SGR(sgr0), .ZF(zf0)
   );

   initial sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   task automatic step();
      @(posedge sysclk);
      #1;
   endtask

   task automatic drive(input logic st, input logic [2:0] o, input logic c,
                        input logic [15:0] rv, input logic [15:0] sv);
      start = st;
      op    = o;
      ci    = c;
      r     = rv;
      s     = sv;
   endtask

   // Observed bundle order: {DONE, BUSY, F, MH, CRY, OVF, SGR, ZF}
   task automatic test_reset();
      logic [37:0] exp;
      sys_rst = 1'b1;
      #1;
      exp = {1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
      vectors++;
      if ({done, busy, f, mh, cry, ovf, sgr, zf} !== exp) begin
         miscompares++;
         $display("[TB] FAIL reset_state got=%h exp=%h", {done, busy, f, mh, cry, ovf, sgr, zf}, exp);
      end
      step();
      step();
      sys_rst = 1'b0;
      step();
   endtask

   task automatic test_add_overflow();
      logic [37:0] exp;
      drive(1'b1, 3'b000, 1'b0, 16'h7FFF, 16'h0001);
      step();
      start = 1'b0;
      exp = {1'b1, 1'b0, 16'h8000, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0};
      vectors++;
      if ({done, busy, f, mh, cry, ovf, sgr, zf} !== exp) begin
         miscompares++;
         $display("[TB] FAIL add_ovf got=%h exp=%h", {done, busy, f, mh, cry, ovf, sgr, zf}, exp);
      end
      step();
      exp = {1'b0, 1'b0, 16'h8000, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0};
      vectors++;
      if ({done, busy, f, mh, cry, ovf, sgr, zf} !== exp) begin
         miscompares++;
         $display("[TB] FAIL add_hold got=%h exp=%h", {done, busy, f, mh, cry, ovf, sgr, zf}, exp);
      end
   endtask

   task automatic test_sub_equal();
      logic [37:0] exp;
      drive(1'b1, 3'b001, 1'b1, 16'h0005, 16'h0005);
      step();
      start = 1'b0;
      exp = {1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1};
      vectors++;
      if ({done, busy, f, mh, cry, ovf, sgr, zf} !== exp) begin
         miscompares++;
         $display("[TB] FAIL sub_equal got=%h exp=%h", {done, busy, f, mh, cry, ovf, sgr, zf}, exp);
      end
      step();
   endtask

   task automatic test_back_to_back();
      logic [37:0] exp;
      drive(1'b1, 3'b000, 1'b0, 16'hFFFF, 16'h0001);
      step();
      exp = {1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1};
      vectors++;
      if ({done, busy, f, mh, cry, ovf, sgr, zf} !== exp) begin
         miscompares++;
         $display("[TB] FAIL b2b_add got=%h exp=%h", {done, busy, f, mh, cry, ovf, sgr, zf}, exp);
      end
      drive(1'b1, 3'b111, 1'b0, 16'h0000, 16'h0000);
      step();
      start = 1'b0;
      exp = {1'b1, 1'b0, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
      vectors++;
      if ({done, busy, f, mh, cry, ovf, sgr, zf} !== exp) begin
         miscompares++;
         $display("[TB] FAIL b2b_addc got=%h exp=%h", {done, busy, f, mh, cry, ovf, sgr, zf}, exp);
      end
      step();
      exp = {1'b0, 1'b0, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
      vectors++;
      if ({done, busy, f, mh, cry, ovf, sgr, zf} !== exp) begin
         miscompares++;
         $display("[TB] FAIL b2b_hold got=%h exp=%h", {done, busy, f, mh, cry, ovf, sgr, zf}, exp);
      end
   endtask

   task automatic test_mul();
      logic [37:0] exp;
      drive(1'b1, 3'b110, 1'b0, 16'h1234, 16'h0100);
      step();
      start = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (i > 0) begin
            if (i == 5) drive(1'b1, 3'b000, 1'b0, 16'h0001, 16'h0001);
            step();
            start = 1'b0;
         end
         vectors++;
         if (busy !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL mul_busy cycle=%0d got busy=%b done=%b exp busy=1 done=0", i, busy, done);
         end
      end
      step();
      exp = {1'b1, 1'b0, 16'h3400, 16'h0012, 1'b0, 1'b1, 1'b0, 1'b0};
      vectors++;
      if ({done, busy, f, mh, cry, ovf, sgr, zf} !== exp) begin
         miscompares++;
         $display("[TB] FAIL mul_result got=%h exp=%h", {done, busy, f, mh, cry, ovf, sgr, zf}, exp);
      end
      step();
      exp = {1'b0, 1'b0, 16'h3400, 16'h0012, 1'b0, 1'b1, 1'b0, 1'b0};
      vectors++;
      if ({done, busy, f, mh, cry, ovf, sgr, zf} !== exp) begin
         miscompares++;
         $display("[TB] FAIL mul_hold got=%h exp=%h", {done, busy, f, mh, cry, ovf, sgr, zf}, exp);
      end
   endtask

   task automatic test_mul_max();
      logic [37:0] exp;
      int          latency;
      drive(1'b1, 3'b110, 1'b0, 16'hFFFF, 16'hFFFF);
      step();
      start = 1'b0;
      latency = 0;
      while (done !== 1'b1 && latency < 40) begin
         step();
         latency++;
      end
      vectors++;
      if (latency != 16) begin
         miscompares++;
         $display("[TB] FAIL mul_latency got=%0d exp=16", latency);
      end
      exp = {1'b1, 1'b0, 16'h0001, 16'hFFFE, 1'b0, 1'b1, 1'b0, 1'b0};
      vectors++;
      if ({done, busy, f, mh, cry, ovf, sgr, zf} !== exp) begin
         miscompares++;
         $display("[TB] FAIL mul_max got=%h exp=%h", {done, busy, f, mh, cry, ovf, sgr, zf}, exp);
      end
      step();
   endtask

   task automatic test_xor();
      logic [37:0] exp;
      drive(1'b1, 3'b100, 1'b0, 16'hAAAA, 16'hAAAA);
      step();
      start = 1'b0;
      exp = {1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1};
      vectors++;
      if ({done, busy, f, mh, cry, ovf, sgr, zf} !== exp) begin
         miscompares++;
         $display("[TB] FAIL xor_zero got=%h exp=%h", {done, busy, f, mh, cry, ovf, sgr, zf}, exp);
      end
      step();
   endtask

   task automatic test_reserved_mul();
      logic [37:0] exp;
      drive(1'b0, 3'b110, 1'b1, 16'h1234, 16'h0100);
      start0 = 1'b1;
      step();
      start0 = 1'b0;
      exp = {1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1};
      vectors++;
      if ({done0, busy0, f0, mh0, cry0, ovf0, sgr0, zf0} !== exp) begin
         miscompares++;
         $display("[TB] FAIL reserved_mul got=%h exp=%h", {done0, busy0, f0, mh0, cry0, ovf0, sgr0, zf0}, exp);
      end
      step();
      vectors++;
      if (done0 !== 1'b0 || busy0 !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reserved_after got done=%b busy=%b exp done=0 busy=0", done0, busy0);
      end
   endtask

   task automatic test_reset_during_mul();
      logic [37:0] exp;
      int          stray;
      drive(1'b1, 3'b110, 1'b0, 16'h1234, 16'h0100);
      step();
      start = 1'b0;
      for (int i = 0; i < 5; i++) step();
      sys_rst = 1'b1;
      #1;
      exp = '0;
      vectors++;
      if ({done, busy, f, mh, cry, ovf, sgr, zf} !== exp) begin
         miscompares++;
         $display("[TB] FAIL rst_abort got=%h exp=%h", {done, busy, f, mh, cry, ovf, sgr, zf}, exp);
      end
      step();
      sys_rst = 1'b0;
      stray = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (done !== 1'b0 || busy !== 1'b0) stray++;
      end
      vectors++;
      if (stray != 0) begin
         miscompares++;
         $display("[TB] FAIL rst_no_done got=%0d active cycles exp=0", stray);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      sys_rst     = 1'b0;
      start0      = 1'b0;
      drive(1'b0, 3'b000, 1'b0, 16'h0000, 16'h0000);
      test_reset();
      test_add_overflow();
      test_sub_equal();
      test_back_to_back();
      test_mul();
      test_mul_max();
      test_xor();
      test_reserved_mul();
      test_reset_during_mul();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
